// File: rtl/tx_fifo_pkg.sv
// Shared SSP constants used by the transmit and receive FIFOs.
package tx_fifo_pkg;

  localparam int SSP_WORD_W     = 8;
  localparam int SSP_FIFO_DEPTH = 4;
  localparam int SSP_PTR_W      = $clog2(SSP_FIFO_DEPTH);
  localparam int SSP_CNT_W      = $clog2(SSP_FIFO_DEPTH + 1);

endpackage

// File: rtl/ssp_fifo_core.sv
// Generic SSP FIFO storage: pointers, occupancy count and full/empty flags.
// Shared by the transmit and receive FIFOs; DEPTH must be a power of two.
module ssp_fifo_core
  import tx_fifo_pkg::*;
#(
  parameter int WIDTH = SSP_WORD_W,
  parameter int DEPTH = SSP_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  // Flags come from the registered count only, never from this cycle's requests.
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; stale words are hidden by the empty flag.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tx_fifo.sv
// SSP transmit FIFO: processor writes fill it, the serialiser drains it,
// and the interrupt stays high while there is no room for another word.
module tx_fifo
  import tx_fifo_pkg::*;
#(
  parameter int WIDTH = SSP_WORD_W,
  parameter int DEPTH = SSP_FIFO_DEPTH
) (
  input  logic             PCLK,
  input  logic             CLEAR,
  input  logic             PSEL,
  input  logic             PWRITE,
  input  logic [WIDTH-1:0] PWDATA,
  input  logic             TxNextWord,
  output logic [WIDTH-1:0] TxData,
  output logic             TxDataValid,
  output logic             SSPTXINTR
);

  logic [WIDTH-1:0] head_word;
  logic             fifo_full;
  logic             fifo_empty;

  ssp_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (PCLK),
    .clear   (CLEAR),
    .push    (PSEL & PWRITE),
    .pop     (TxNextWord),
    .wr_data (PWDATA),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign TxDataValid = ~fifo_empty;
  assign SSPTXINTR   = fifo_full;
  assign TxData      = fifo_empty ? '0 : head_word;

endmodule
